// File: rtl/video_stream_source.sv
// AXI4-Stream video master: scans a framebuffer (or a test pattern)
// into 32-bit pixel beats with SOF on tuser and EOL on tlast.
module video_stream_source #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        m_axis_vid_aclk,
  input  logic        aresetn,
  input  logic        enable,
  input  logic [31:0] cfg_base,
  input  logic [11:0] cfg_width,
  input  logic [11:0] cfg_height,
  input  logic [15:0] cfg_stride,
  input  logic        cfg_pattern,
  output logic        fb_rd_en,
  output logic [31:0] fb_rd_addr,
  input  logic [31:0] fb_rd_data,
  output logic [31:0] m_axis_vid_tdata,
  output logic        m_axis_vid_tvalid,
  input  logic        m_axis_vid_tready,
  output logic        m_axis_vid_tlast,
  output logic        m_axis_vid_tuser,
  output logic        frame_done,
  output logic        busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [11:0] r_width;
  logic [11:0] r_height;
  logic [15:0] r_stride;
  logic        r_pattern;
  logic [11:0] r_x;
  logic [11:0] r_y;
  logic [31:0] r_line_addr;

  logic          r_pend;
  logic          r_pend_user;
  logic          r_pend_last;
  logic [31:0]   r_pend_pat;

  logic [33:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic r_frame_done;
  logic r_busy;

  logic          w_start;
  logic [CW-1:0] w_occ;
  logic          w_issue;
  logic          w_x_end;
  logic          w_last_rd;
  logic          w_tvalid;
  logic          w_pop;
  logic          w_push;
  logic          w_final;
  logic [31:0]   w_push_data;
  logic [33:0]   w_head;
  logic [31:0]   w_pat;

  assign w_start = (r_state == S_IDLE) && enable &&
                   (cfg_width != 12'd0) && (cfg_height != 12'd0);
  assign w_occ     = r_count + CW'(r_pend);
  assign w_issue   = (r_state == S_RUN) && (w_occ < CW'(FIFO_DEPTH));
  assign w_x_end   = (r_x == r_width - 12'd1);
  assign w_last_rd = w_issue && w_x_end && (r_y == r_height - 12'd1);
  assign w_tvalid  = (r_count != '0);
  assign w_pop     = w_tvalid && m_axis_vid_tready;
  assign w_push    = r_pend;
  assign w_final   = (r_state == S_FLUSH) && w_pop &&
                     (r_count == CW'(1)) && !r_pend;
  assign w_push_data = r_pattern ? r_pend_pat : fb_rd_data;
  assign w_head = r_mem[r_rd_ptr];
  assign w_pat  = {8'h00, r_x[7:0], r_y[7:0], r_x[7:0] ^ r_y[7:0]};

  assign fb_rd_en   = w_issue && !r_pattern;
  assign fb_rd_addr = r_line_addr + {20'd0, r_x};

  assign m_axis_vid_tdata  = w_head[31:0];
  assign m_axis_vid_tvalid = w_tvalid;
  assign m_axis_vid_tlast  = w_tvalid && w_head[32];
  assign m_axis_vid_tuser  = w_tvalid && w_head[33];
  assign frame_done = r_frame_done;
  assign busy       = r_busy;

  // state register
  always_ff @(posedge m_axis_vid_aclk) begin
    if (!aresetn) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // next-state: start, last read issued, final handshake
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (w_start)   w_state_nxt = S_RUN;
      S_RUN:   if (w_last_rd) w_state_nxt = S_FLUSH;
      S_FLUSH: if (w_final)   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // frame config latch and raster position
  always_ff @(posedge m_axis_vid_aclk) begin
    if (!aresetn) begin
      r_width     <= '0;
      r_height    <= '0;
      r_stride    <= '0;
      r_pattern   <= 1'b0;
      r_x         <= '0;
      r_y         <= '0;
      r_line_addr <= '0;
    end else if (w_start) begin
      r_width     <= cfg_width;
      r_height    <= cfg_height;
      r_stride    <= cfg_stride;
      r_pattern   <= cfg_pattern;
      r_x         <= '0;
      r_y         <= '0;
      r_line_addr <= cfg_base;
    end else if (w_issue) begin
      if (w_x_end) begin
        r_x         <= '0;
        r_y         <= r_y + 12'd1;
        r_line_addr <= r_line_addr + {16'd0, r_stride};
      end else begin
        r_x <= r_x + 12'd1;
      end
    end
  end

  // one-deep in-flight slot matching RAM read latency
  always_ff @(posedge m_axis_vid_aclk) begin
    if (!aresetn) begin
      r_pend      <= 1'b0;
      r_pend_user <= 1'b0;
      r_pend_last <= 1'b0;
      r_pend_pat  <= '0;
    end else begin
      r_pend      <= w_issue;
      r_pend_user <= (r_x == 12'd0) && (r_y == 12'd0);
      r_pend_last <= w_x_end;
      r_pend_pat  <= w_pat;
    end
  end

  // FIFO storage
  always_ff @(posedge m_axis_vid_aclk) begin
    if (w_push) r_mem[r_wr_ptr] <= {r_pend_user, r_pend_last, w_push_data};
  end

  // FIFO pointers and occupancy
  always_ff @(posedge m_axis_vid_aclk) begin
    if (!aresetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // frame status flags
  always_ff @(posedge m_axis_vid_aclk) begin
    if (!aresetn) begin
      r_frame_done <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_frame_done <= w_final;
      if (w_start)      r_busy <= 1'b1;
      else if (w_final) r_busy <= 1'b0;
    end
  end

endmodule

// File: tb/tb_video_stream_source.sv
// Directed bench for video_stream_source: raster order, stalls,
// pattern mode, atomic frames, mid-frame reset, 1x1 frames.
module tb_video_stream_source;

  logic        clk = 1'b0;
  logic        aresetn;
  logic        enable;
  logic [31:0] cfg_base;
  logic [11:0] cfg_width;
  logic [11:0] cfg_height;
  logic [15:0] cfg_stride;
  logic        cfg_pattern;
  logic        fb_rd_en;
  logic [31:0] fb_rd_addr;
  logic [31:0] fb_rd_data;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        tlast;
  logic        tuser;
  logic        frame_done;
  logic        busy;

  logic rnd;
  logic rbit;
  logic fixed_ready;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  video_stream_source #(.FIFO_DEPTH(4)) dut (
    .m_axis_vid_aclk  (clk),
    .aresetn          (aresetn),
    .enable           (enable),
    .cfg_base         (cfg_base),
    .cfg_width        (cfg_width),
    .cfg_height       (cfg_height),
    .cfg_stride       (cfg_stride),
    .cfg_pattern      (cfg_pattern),
    .fb_rd_en         (fb_rd_en),
    .fb_rd_addr       (fb_rd_addr),
    .fb_rd_data       (fb_rd_data),
    .m_axis_vid_tdata (tdata),
    .m_axis_vid_tvalid(tvalid),
    .m_axis_vid_tready(tready),
    .m_axis_vid_tlast (tlast),
    .m_axis_vid_tuser (tuser),
    .frame_done       (frame_done),
    .busy             (busy)
  );

  function automatic logic [31:0] ram_f(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  // synchronous RAM, 1-cycle read latency
  always @(posedge clk) if (fb_rd_en) fb_rd_data <= ram_f(fb_rd_addr);

  always @(posedge clk) rbit <= 1'($urandom_range(0, 1));
  assign tready = rnd ? rbit : fixed_ready;

  // beat / read / frame_done recorder
  int cyc = 0;
  int nb = 0;
  int nr = 0;
  int ndone = 0;
  int last_pop_cyc = 0;
  int done_gap = 0;
  logic done_busy = 1'b1;
  int viol_stab = 0;
  int viol_occ = 0;
  int occ = 0;
  logic p_stall = 1'b0;
  logic [33:0] p_pay;
  logic [31:0] bd [1024];
  logic        bl [1024];
  logic        bu [1024];
  logic [31:0] ra [1024];

  always @(negedge clk) begin
    cyc++;
    if (!aresetn) begin
      occ = 0;
      p_stall = 1'b0;
    end else begin
      if (p_stall && (!tvalid || {tuser, tlast, tdata} !== p_pay))
        viol_stab++;
      p_stall = tvalid && !tready;
      p_pay = {tuser, tlast, tdata};
      if (!cfg_pattern && occ > 4) viol_occ++;
      if (frame_done) begin
        ndone++;
        done_gap = cyc - last_pop_cyc;
        done_busy = busy;
      end
      if (fb_rd_en) begin
        ra[nr % 1024] = fb_rd_addr;
        nr++;
        if (!cfg_pattern) occ++;
      end
      if (tvalid && tready) begin
        bd[nb % 1024] = tdata;
        bl[nb % 1024] = tlast;
        bu[nb % 1024] = tuser;
        nb++;
        last_pop_cyc = cyc;
        if (!cfg_pattern) occ--;
      end
      if (!busy && !tvalid) occ = 0;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic set_cfg(input logic [31:0] b, input logic [11:0] w,
                         input logic [11:0] h, input logic [15:0] s,
                         input logic p);
    cfg_base = b;
    cfg_width = w;
    cfg_height = h;
    cfg_stride = s;
    cfg_pattern = p;
  endtask

  task automatic wait_done(input int d0, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (ndone > d0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_beats(input int tgt, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (nb >= tgt) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    enable = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if (tvalid !== 1'b0) begin
      n_bad++; $display("FAIL rst_tvalid: got %b want 0", tvalid);
    end
    n_cmp++;
    if (tlast !== 1'b0 || tuser !== 1'b0) begin
      n_bad++; $display("FAIL rst_tlast_tuser: got %b%b want 00", tlast, tuser);
    end
    n_cmp++;
    if (fb_rd_en !== 1'b0) begin
      n_bad++; $display("FAIL rst_rd_en: got %b want 0", fb_rd_en);
    end
    n_cmp++;
    if (frame_done !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL rst_done_busy: got %b%b want 00", frame_done, busy);
    end
    aresetn = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [31:0] ea [8];
    int b0;
    int r0;
    int d0;
    bit ok;
    ea = '{32'h100, 32'h101, 32'h102, 32'h103,
           32'h108, 32'h109, 32'h10A, 32'h10B};
    set_cfg(32'h100, 12'd4, 12'd2, 16'd8, 1'b0);
    b0 = nb; r0 = nr; d0 = ndone;
    enable = 1'b1;
    @(posedge clk);
    #1 enable = 1'b0;
    @(negedge clk);
    #1;
    n_cmp++;
    if (fb_rd_en !== 1'b1 || tvalid !== 1'b0) begin
      n_bad++; $display("FAIL lat_first_read: rd_en=%b tvalid=%b want 1 0", fb_rd_en, tvalid);
    end
    tick();
    n_cmp++;
    if (tvalid !== 1'b0) begin
      n_bad++; $display("FAIL lat_e2: tvalid got %b want 0", tvalid);
    end
    tick();
    n_cmp++;
    if (tvalid !== 1'b1 || tuser !== 1'b1) begin
      n_bad++; $display("FAIL lat_e3: tvalid/tuser got %b%b want 11", tvalid, tuser);
    end
    wait_done(d0, 100, ok);
    n_cmp++;
    if (!ok) begin
      n_bad++; $display("FAIL basic_timeout: frame_done got 0 want 1");
    end
    repeat (3) tick();
    n_cmp++;
    if (nr - r0 !== 8 || nb - b0 !== 8 || ndone - d0 !== 1) begin
      n_bad++;
      $display("FAIL basic_counts: reads %0d beats %0d done %0d want 8 8 1",
               nr - r0, nb - b0, ndone - d0);
    end
    n_cmp++;
    if (done_gap !== 1 || done_busy !== 1'b0) begin
      n_bad++; $display("FAIL basic_done: gap %0d busy %b want 1 0", done_gap, done_busy);
    end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (ra[r0 + i] !== ea[i] || bd[b0 + i] !== ram_f(ea[i]) ||
          bu[b0 + i] !== (i == 0) || bl[b0 + i] !== (i == 3 || i == 7)) begin
        n_bad++;
        $display("FAIL basic_beat%0d: addr %h data %h u%b l%b want addr %h data %h",
                 i, ra[r0 + i], bd[b0 + i], bu[b0 + i], bl[b0 + i], ea[i], ram_f(ea[i]));
      end
    end
  endtask

  task automatic test_random_ready();
    logic [31:0] ea [8];
    int b0;
    int d0;
    int vs0;
    int vo0;
    bit ok;
    ea = '{32'h100, 32'h101, 32'h102, 32'h103,
           32'h108, 32'h109, 32'h10A, 32'h10B};
    b0 = nb; d0 = ndone; vs0 = viol_stab; vo0 = viol_occ;
    rnd = 1'b1;
    enable = 1'b1;
    tick();
    enable = 1'b0;
    wait_done(d0, 400, ok);
    rnd = 1'b0;
    n_cmp++;
    if (!ok) begin
      n_bad++; $display("FAIL rand_timeout: frame_done got 0 want 1");
    end
    repeat (3) tick();
    n_cmp++;
    if (nb - b0 !== 8) begin
      n_bad++; $display("FAIL rand_beats: got %0d want 8", nb - b0);
    end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (bd[b0 + i] !== ram_f(ea[i])) begin
        n_bad++;
        $display("FAIL rand_beat%0d: got %h want %h", i, bd[b0 + i], ram_f(ea[i]));
      end
    end
    n_cmp++;
    if (viol_stab - vs0 !== 0) begin
      n_bad++; $display("FAIL rand_stable: got %0d changes want 0", viol_stab - vs0);
    end
    n_cmp++;
    if (viol_occ - vo0 !== 0) begin
      n_bad++; $display("FAIL rand_occupancy: got %0d overflows want 0", viol_occ - vo0);
    end
  endtask

  task automatic test_pattern();
    int b0;
    int r0;
    int d0;
    bit ok;
    set_cfg(32'h0, 12'd3, 12'd2, 16'd3, 1'b1);
    b0 = nb; r0 = nr; d0 = ndone;
    enable = 1'b1;
    tick();
    enable = 1'b0;
    wait_done(d0, 100, ok);
    repeat (3) tick();
    n_cmp++;
    if (!ok || nb - b0 !== 6 || nr - r0 !== 0) begin
      n_bad++;
      $display("FAIL pat_counts: done %b beats %0d reads %0d want 1 6 0", ok, nb - b0, nr - r0);
    end
    n_cmp++;
    if (bd[b0 + 5] !== 32'h00020103 || bl[b0 + 5] !== 1'b1) begin
      n_bad++;
      $display("FAIL pat_x2y1: got %h l%b want 00020103 l1", bd[b0 + 5], bl[b0 + 5]);
    end
    n_cmp++;
    if (bd[b0 + 1] !== 32'h00010001 || bd[b0 + 3] !== 32'h00000101) begin
      n_bad++;
      $display("FAIL pat_x1y0_x0y1: got %h %h want 00010001 00000101", bd[b0 + 1], bd[b0 + 3]);
    end
    n_cmp++;
    if (bu[b0] !== 1'b1 || bu[b0 + 3] !== 1'b0 || bl[b0 + 2] !== 1'b1) begin
      n_bad++;
      $display("FAIL pat_flags: got u0=%b u3=%b l2=%b want 1 0 1", bu[b0], bu[b0 + 3], bl[b0 + 2]);
    end
    cfg_pattern = 1'b0;
  endtask

  task automatic test_zero_size();
    int b0;
    int r0;
    int busy_seen;
    b0 = nb; r0 = nr; busy_seen = 0;
    set_cfg(32'h0, 12'd0, 12'd2, 16'd4, 1'b0);
    enable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (busy) busy_seen++;
    end
    cfg_width = 12'd2;
    cfg_height = 12'd0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (busy) busy_seen++;
    end
    enable = 1'b0;
    tick();
    n_cmp++;
    if (busy_seen !== 0 || nb - b0 !== 0 || nr - r0 !== 0) begin
      n_bad++;
      $display("FAIL zero_size: busy %0d beats %0d reads %0d want 0 0 0",
               busy_seen, nb - b0, nr - r0);
    end
  endtask

  task automatic test_enable_drop();
    int b0;
    int d0;
    int nu;
    int nl;
    bit ok;
    set_cfg(32'h200, 12'd4, 12'd4, 16'd4, 1'b0);
    b0 = nb; d0 = ndone;
    enable = 1'b1;
    wait_beats(b0 + 2, 100, ok);
    enable = 1'b0;
    n_cmp++;
    if (!ok) begin
      n_bad++; $display("FAIL drop_start_timeout: beats %0d want 2", nb - b0);
    end
    wait_done(d0, 200, ok);
    repeat (20) tick();
    nu = 0; nl = 0;
    for (int i = b0; i < nb; i++) begin
      if (bu[i]) nu++;
      if (bl[i]) nl++;
    end
    n_cmp++;
    if (!ok || nb - b0 !== 16 || ndone - d0 !== 1) begin
      n_bad++;
      $display("FAIL drop_counts: beats %0d done %0d want 16 1", nb - b0, ndone - d0);
    end
    n_cmp++;
    if (nu !== 1 || nl !== 4 || busy !== 1'b0) begin
      n_bad++; $display("FAIL drop_flags: tuser %0d tlast %0d busy %b want 1 4 0", nu, nl, busy);
    end
    n_cmp++;
    if (bd[b0 + 15] !== ram_f(32'h20F)) begin
      n_bad++; $display("FAIL drop_last_data: got %h want %h", bd[b0 + 15], ram_f(32'h20F));
    end
  endtask

  task automatic test_reset_mid();
    int b0;
    int b1;
    int r1;
    int d1;
    bit ok;
    set_cfg(32'h300, 12'd4, 12'd2, 16'd4, 1'b0);
    b0 = nb;
    enable = 1'b1;
    wait_beats(b0 + 5, 100, ok);
    @(posedge clk);
    #1 aresetn = 1'b0;
    @(posedge clk);
    tick();
    n_cmp++;
    if (!ok || tvalid !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL rstmid_clear: tvalid %b busy %b want 0 0", tvalid, busy);
    end
    aresetn = 1'b1;
    b1 = nb; r1 = nr; d1 = ndone;
    wait_beats(b1 + 1, 50, ok);
    enable = 1'b0;
    n_cmp++;
    if (!ok || bu[b1] !== 1'b1 || bd[b1] !== ram_f(32'h300) || ra[r1] !== 32'h300) begin
      n_bad++;
      $display("FAIL rstmid_restart: u%b data %h addr %h want u1 %h 00000300",
               bu[b1], bd[b1], ra[r1], ram_f(32'h300));
    end
    wait_done(d1, 100, ok);
    repeat (3) tick();
    n_cmp++;
    if (!ok || nb - b1 !== 8) begin
      n_bad++; $display("FAIL rstmid_frame: beats %0d want 8", nb - b1);
    end
  endtask

  task automatic test_w1h1();
    int b0;
    int d0;
    bit ok;
    ok = 1'b0;
    set_cfg(32'h400, 12'd1, 12'd1, 16'd1, 1'b0);
    b0 = nb; d0 = ndone;
    enable = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (ndone - d0 >= 2) begin
        ok = 1'b1;
        break;
      end
    end
    enable = 1'b0;
    repeat (10) tick();
    n_cmp++;
    if (!ok || nb - b0 !== 2 || ndone - d0 !== 2) begin
      n_bad++;
      $display("FAIL w1h1_counts: beats %0d done %0d want 2 2", nb - b0, ndone - d0);
    end
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (bu[b0 + i] !== 1'b1 || bl[b0 + i] !== 1'b1 || bd[b0 + i] !== ram_f(32'h400)) begin
        n_bad++;
        $display("FAIL w1h1_beat%0d: u%b l%b data %h want u1 l1 %h",
                 i, bu[b0 + i], bl[b0 + i], bd[b0 + i], ram_f(32'h400));
      end
    end
  endtask

  initial begin
    rnd = 1'b0;
    fixed_ready = 1'b1;
    set_cfg(32'h0, 12'd0, 12'd0, 16'd0, 1'b0);
    test_reset();
    test_basic();
    test_random_ready();
    test_pattern();
    test_zero_size();
    test_enable_drop();
    test_reset_mid();
    test_w1h1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
